player_shooter: RTL and testbench

PLAYER_SHOOTER -- requirements
Module: player_shooter

---
 rtl/player_shooter.sv | 126 ++++++++++++
 tb/tb_player_shooter.sv | 341 ++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/player_shooter.sv
// Player cannon for an invaders-style game: column movement, single-bullet
// firing with a post-shot cooldown, and hit scoring. All outputs registered.
module player_shooter #(
    parameter int MOVE_DIV   = 200000,
    parameter int BULLET_DIV = 50000,
    parameter int COOLDOWN   = 2
) (
    input  logic       clk_36MHz,
    input  logic       reset,
    input  logic       start,
    input  logic       btn_left,
    input  logic       btn_right,
    input  logic       btn_fire,
    input  logic       hit,
    output logic [4:0] player_x,
    output logic [4:0] bullet_x,
    output logic [3:0] bullet_y,
    output logic       bullet_active,
    output logic [7:0] score
);

    localparam int MW = $clog2(MOVE_DIV + 1);
    localparam int BW = $clog2(BULLET_DIV + 1);
    localparam int CW = $clog2(COOLDOWN + 2);
    localparam logic [MW-1:0] MOVE_LAST   = MW'(MOVE_DIV - 1);
    localparam logic [BW-1:0] BULLET_LAST = BW'(BULLET_DIV - 1);
    localparam logic [CW-1:0] CD_LAST     = CW'((COOLDOWN > 0) ? COOLDOWN - 1 : 0);

    typedef enum logic [1:0] {S_WAIT, S_READY, S_FLYING, S_COOLDOWN} state_t;

    state_t          r_state;
    logic [MW-1:0]   r_move_cnt;
    logic [BW-1:0]   r_bullet_cnt;
    logic [CW-1:0]   r_cd_cnt;
    logic            r_fire_hist;
    logic [4:0]      r_player_x;
    logic [4:0]      r_bullet_x;
    logic [3:0]      r_bullet_y;
    logic            r_bullet_active;
    logic [7:0]      r_score;

    logic w_move_tick;
    logic w_bullet_tick;
    logic w_fire_edge;

    assign w_move_tick   = (r_move_cnt == MOVE_LAST);
    assign w_bullet_tick = (r_bullet_cnt == BULLET_LAST);
    assign w_fire_edge   = btn_fire & ~r_fire_hist;

    always_ff @(posedge clk_36MHz) begin
        if (reset) begin
            r_state         <= S_WAIT;
            r_move_cnt      <= '0;
            r_bullet_cnt    <= '0;
            r_cd_cnt        <= '0;
            r_fire_hist     <= 1'b1;
            r_player_x      <= 5'd10;
            r_bullet_x      <= '0;
            r_bullet_y      <= '0;
            r_bullet_active <= 1'b0;
            r_score         <= '0;
        end else begin
            r_move_cnt   <= w_move_tick ? '0 : r_move_cnt + 1'b1;
            r_bullet_cnt <= w_bullet_tick ? '0 : r_bullet_cnt + 1'b1;
            r_fire_hist  <= btn_fire;

            if (r_state != S_WAIT && w_move_tick) begin
                if (btn_left && !btn_right && r_player_x < 5'd19)
                    r_player_x <= r_player_x + 1'b1;
                else if (btn_right && !btn_left && r_player_x != 5'd0)
                    r_player_x <= r_player_x - 1'b1;
            end

            case (r_state)
                S_WAIT: begin
                    if (start) r_state <= S_READY;
                end
                S_READY: begin
                    // bullet_x latches the pre-move column of this edge
                    if (w_fire_edge) begin
                        r_bullet_x      <= r_player_x;
                        r_bullet_y      <= 4'd14;
                        r_bullet_active <= 1'b1;
                        r_state         <= S_FLYING;
                    end
                end
                S_FLYING: begin
                    if (hit) begin
                        if (r_score != 8'hFF) r_score <= r_score + 1'b1;
                        r_bullet_x      <= '0;
                        r_bullet_y      <= '0;
                        r_bullet_active <= 1'b0;
                        r_cd_cnt        <= '0;
                        r_state         <= S_COOLDOWN;
                    end else if (w_bullet_tick) begin
                        if (r_bullet_y != 4'd0) begin
                            r_bullet_y <= r_bullet_y - 1'b1;
                        end else begin
                            r_bullet_active <= 1'b0;
                            r_cd_cnt        <= '0;
                            r_state         <= S_COOLDOWN;
                        end
                    end
                end
                S_COOLDOWN: begin
                    if (w_bullet_tick) begin
                        if (r_cd_cnt >= CD_LAST) begin
                            r_cd_cnt <= '0;
                            r_state  <= S_READY;
                        end else begin
                            r_cd_cnt <= r_cd_cnt + 1'b1;
                        end
                    end
                end
                default: r_state <= S_WAIT;
            endcase
        end
    end

    assign player_x      = r_player_x;
    assign bullet_x      = r_bullet_x;
    assign bullet_y      = r_bullet_y;
    assign bullet_active = r_bullet_active;
    assign score         = r_score;

endmodule

// File: tb/tb_player_shooter.sv
// Self-checking bench for player_shooter with small dividers, comparing
// against a cycle-count based behavioural model.
module tb_player_shooter;

    localparam int MD = 4;
    localparam int BD = 4;
    localparam int CD = 2;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic       reset, start, btn_left, btn_right, btn_fire, hit;
    logic [4:0] player_x, bullet_x;
    logic [3:0] bullet_y;
    logic       bullet_active;
    logic [7:0] score;

    int errors = 0;
    int checks = 0;

    player_shooter #(.MOVE_DIV(MD), .BULLET_DIV(BD), .COOLDOWN(CD)) dut (
        .clk_36MHz(clk), .reset(reset), .start(start),
        .btn_left(btn_left), .btn_right(btn_right), .btn_fire(btn_fire), .hit(hit),
        .player_x(player_x), .bullet_x(bullet_x), .bullet_y(bullet_y),
        .bullet_active(bullet_active), .score(score)
    );

    // Behavioural model: ticks derive from cycles elapsed since reset.
    typedef enum {M_WAIT, M_READY, M_FLY, M_CD} mode_t;
    mode_t      m_mode, old_mode;
    logic [4:0] m_px, m_bx, old_px;
    logic [3:0] m_by;
    logic       m_act, m_prev_fire;
    logic [7:0] m_score;
    int         m_cnt, m_cd;
    bit         mt, bt, fe;

    always @(posedge clk) begin
        if (reset) begin
            m_mode = M_WAIT; m_px = 5'd10; m_bx = '0; m_by = '0; m_act = 1'b0;
            m_score = '0; m_cnt = 0; m_cd = 0; m_prev_fire = 1'b1;
        end else begin
            mt = (m_cnt % MD) == MD - 1;
            bt = (m_cnt % BD) == BD - 1;
            fe = btn_fire && !m_prev_fire;
            m_prev_fire = btn_fire;
            m_cnt++;
            old_px = m_px;
            old_mode = m_mode;
            if (old_mode != M_WAIT && mt) begin
                if (btn_left && !btn_right && m_px < 19) m_px = m_px + 1;
                else if (btn_right && !btn_left && m_px > 0) m_px = m_px - 1;
            end
            case (old_mode)
                M_WAIT:  if (start) m_mode = M_READY;
                M_READY: if (fe) begin
                    m_bx = old_px; m_by = 14; m_act = 1'b1; m_mode = M_FLY;
                end
                M_FLY: if (hit) begin
                    m_score = (m_score == 255) ? 8'd255 : m_score + 1;
                    m_bx = 0; m_by = 0; m_act = 0; m_cd = 0; m_mode = M_CD;
                end else if (bt) begin
                    if (m_by > 0) m_by = m_by - 1;
                    else begin m_act = 0; m_cd = 0; m_mode = M_CD; end
                end
                M_CD: if (bt) begin
                    m_cd++;
                    if (m_cd >= CD) begin m_cd = 0; m_mode = M_READY; end
                end
                default: ;
            endcase
        end
    end

    function automatic logic [22:0] exp_vec();
        return {m_px, m_bx, m_by, m_act, m_score};
    endfunction

    function automatic logic [22:0] dut_vec();
        return {player_x, bullet_x, bullet_y, bullet_active, score};
    endfunction

    task automatic step();
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic clear_inputs();
        start = 0; btn_left = 0; btn_right = 0; btn_fire = 0; hit = 0;
    endtask

    task automatic reset_and_start();
        clear_inputs();
        reset = 1; step(); reset = 0;
        start = 1; step(); start = 0;
    endtask

    task automatic test_reset();
        reset = 1;
        start = 1'($urandom); btn_left = 1'($urandom); btn_right = 1'($urandom);
        btn_fire = 1'($urandom); hit = 1'($urandom);
        step();
        checks++;
        if (dut_vec() !== {5'd10, 5'd0, 4'd0, 1'b0, 8'd0}) begin
            errors++;
            $display("FAIL reset_values: got %h required %h", dut_vec(), {5'd10, 5'd0, 4'd0, 1'b0, 8'd0});
        end
        reset = 0; clear_inputs();
        repeat (8) begin
            btn_left = 1;
            step();
            checks++;
            if (player_x !== 5'd10) begin
                errors++;
                $display("FAIL wait_no_move: player_x=%0d required 10", player_x);
            end
        end
        btn_left = 0;
    endtask

    task automatic test_move();
        reset_and_start();
        btn_left = 1;
        repeat (60) begin
            step();
            checks++;
            if (dut_vec() !== exp_vec()) begin
                errors++;
                $display("FAIL move_left: got %h required %h", dut_vec(), exp_vec());
            end
        end
        checks++;
        if (player_x !== 5'd19) begin
            errors++;
            $display("FAIL move_stop19: player_x=%0d required 19", player_x);
        end
        btn_right = 1;
        repeat (20) begin
            step();
            checks++;
            if (player_x !== 5'd19 || dut_vec() !== exp_vec()) begin
                errors++;
                $display("FAIL move_both: got %h required %h", dut_vec(), exp_vec());
            end
        end
        btn_left = 0;
        repeat (90) begin
            step();
            checks++;
            if (dut_vec() !== exp_vec()) begin
                errors++;
                $display("FAIL move_right: got %h required %h", dut_vec(), exp_vec());
            end
        end
        checks++;
        if (player_x !== 5'd0) begin
            errors++;
            $display("FAIL move_stop0: player_x=%0d required 0", player_x);
        end
        btn_right = 0;
    endtask

    task automatic test_fire_miss();
        bit done = 0;
        reset_and_start();
        btn_fire = 1; step(); btn_fire = 0;
        checks++;
        if ({bullet_x, bullet_y, bullet_active} !== {5'd10, 4'd14, 1'b1}) begin
            errors++;
            $display("FAIL fire_launch: x=%0d y=%0d act=%0d required 10 14 1", bullet_x, bullet_y, bullet_active);
        end
        for (int i = 0; i < 100 && !done; i++) begin
            step();
            checks++;
            if (dut_vec() !== exp_vec()) begin
                errors++;
                $display("FAIL fire_flight: got %h required %h", dut_vec(), exp_vec());
            end
            if (!bullet_active) done = 1;
        end
        checks++;
        if (!done || score !== 8'd0 || bullet_y !== 4'd0) begin
            errors++;
            $display("FAIL fire_miss_end: done=%0d score=%0d y=%0d required 1 0 0", done, score, bullet_y);
        end
    endtask

    task automatic test_hit();
        bit found = 0;
        reset_and_start();
        btn_fire = 1; step(); btn_fire = 0;
        for (int i = 0; i < 200 && !found; i++) begin
            if (m_mode == M_FLY && m_by == 5 && (m_cnt % BD) == BD - 1) found = 1;
            else step();
        end
        checks++;
        if (!found || bullet_y !== 4'd5) begin
            errors++;
            $display("FAIL hit_setup: found=%0d y=%0d required 1 5", found, bullet_y);
        end
        hit = 1; step(); hit = 0;
        checks++;
        if ({bullet_y, bullet_x, bullet_active, score} !== {4'd0, 5'd0, 1'b0, 8'd1}) begin
            errors++;
            $display("FAIL hit_score: y=%0d x=%0d act=%0d score=%0d required 0 0 0 1", bullet_y, bullet_x, bullet_active, score);
        end
        found = 0;
        for (int i = 0; i < 40 && !found; i++) begin
            if (m_mode == M_CD && m_cd == 1) found = 1;
            else step();
        end
        btn_fire = 1; step(); btn_fire = 0; step();
        checks++;
        if (!found || bullet_active !== 1'b0) begin
            errors++;
            $display("FAIL cooldown_block: found=%0d act=%0d required 1 0", found, bullet_active);
        end
        found = 0;
        for (int i = 0; i < 40 && !found; i++) begin
            if (m_mode == M_READY) found = 1;
            else step();
        end
        btn_fire = 1; step(); btn_fire = 0;
        checks++;
        if (!found || bullet_active !== 1'b1 || dut_vec() !== exp_vec()) begin
            errors++;
            $display("FAIL ready_refire: got %h required %h", dut_vec(), exp_vec());
        end
    endtask

    task automatic test_back_to_back();
        int shots = 0;
        logic prev_act = 0;
        reset_and_start();
        btn_fire = 1;
        repeat (150) begin
            step();
            if (bullet_active && !prev_act) shots++;
            prev_act = bullet_active;
            checks++;
            if (dut_vec() !== exp_vec()) begin
                errors++;
                $display("FAIL held_fire: got %h required %h", dut_vec(), exp_vec());
            end
        end
        btn_fire = 0;
        checks++;
        if (shots != 1) begin
            errors++;
            $display("FAIL held_fire_shots: shots=%0d required 1", shots);
        end
    endtask

    task automatic test_reset_midflight();
        reset_and_start();
        btn_fire = 1; step(); btn_fire = 0;
        repeat (5) step();
        btn_fire = 1; reset = 1; step(); reset = 0;
        checks++;
        if (dut_vec() !== {5'd10, 5'd0, 4'd0, 1'b0, 8'd0}) begin
            errors++;
            $display("FAIL midflight_reset: got %h required %h", dut_vec(), {5'd10, 5'd0, 4'd0, 1'b0, 8'd0});
        end
        start = 1;
        repeat (30) begin
            step();
            checks++;
            if (bullet_active !== 1'b0 || dut_vec() !== exp_vec()) begin
                errors++;
                $display("FAIL held_through_reset: got %h required %h", dut_vec(), exp_vec());
            end
        end
        start = 0;
        btn_fire = 0; step(); btn_fire = 1; step(); btn_fire = 0;
        checks++;
        if (bullet_active !== 1'b1) begin
            errors++;
            $display("FAIL refire_after_release: act=%0d required 1", bullet_active);
        end
    endtask

    task automatic test_saturate();
        reset_and_start();
        for (int i = 0; i < 256; i++) begin
            for (int w = 0; w < 40 && m_mode != M_READY; w++) step();
            btn_fire = 1; step();
            btn_fire = 0; hit = 1; step(); hit = 0;
            checks++;
            if (dut_vec() !== exp_vec()) begin
                errors++;
                $display("FAIL sat_hit%0d: got %h required %h", i, dut_vec(), exp_vec());
            end
            if (i == 254) begin
                checks++;
                if (score !== 8'd255) begin
                    errors++;
                    $display("FAIL sat_reach: score=%0d required 255", score);
                end
            end
        end
        checks++;
        if (score !== 8'd255) begin
            errors++;
            $display("FAIL sat_hold: score=%0d required 255", score);
        end
    endtask

    task automatic test_random();
        reset_and_start();
        repeat (3000) begin
            reset     = ($urandom % 400) == 0;
            start     = ($urandom % 8) == 0;
            btn_left  = 1'($urandom);
            btn_right = ($urandom % 3) == 0;
            btn_fire  = ($urandom % 4) == 0;
            hit       = ($urandom % 6) == 0;
            step();
            checks++;
            if (dut_vec() !== exp_vec()) begin
                errors++;
                $display("FAIL random: got %h required %h", dut_vec(), exp_vec());
            end
        end
        reset = 0; clear_inputs();
    endtask

    initial begin
        reset = 1; clear_inputs();
        test_reset();
        test_move();
        test_fire_miss();
        test_hit();
        test_back_to_back();
        test_reset_midflight();
        test_saturate();
        test_random();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
